// File: rtl/exec_sched_pkg.sv
// Shared definitions for the execute-stage issue scheduler.
// Opcode constants mirror the rvi32 instruction header values.
package exec_sched_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_BR_WAIT = 2'd2
   } sched_state_e;

   function automatic logic is_branch(input logic [6:0] opc);
      return (opc == OPC_BRANCH) ||
             (opc == OPC_JAL) ||
             (opc == OPC_JALR);
   endfunction

endpackage

// File: rtl/uop_fifo.sv
// Synchronous uop FIFO with extra-MSB pointers and a flush input.
module uop_fifo #(
   parameter int DEPTH = 4,
   parameter int UOPW  = 17
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [UOPW-1:0]          wdata_i,
   input  logic                     pop_i,
   output logic [UOPW-1:0]          rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [UOPW-1:0] mem_q [DEPTH];
   logic [AW:0]     wptr_q, rptr_q;
   logic            do_push, do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q[AW-1:0]];
   assign empty_o = (wptr_q == rptr_q);
   // Same slot index but different lap bit means the writer lapped the reader.
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign count_o = wptr_q - rptr_q;

endmodule

// File: rtl/exec_issue_sched.sv
// In-order uop issue scheduler: buffers decoded uops and stalls
// issue behind an unresolved branch, flushing on mispredict.
module exec_issue_sched
   import exec_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int UOPW  = 17
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   dec_valid,
   output logic                   dec_ready,
   input  logic [6:0]             dec_opcode,
   input  logic [2:0]             dec_funct3,
   input  logic [6:0]             dec_funct7,
   output logic                   iss_valid,
   output logic [6:0]             iss_opcode,
   output logic [2:0]             iss_funct3,
   output logic [6:0]             iss_funct7,
   input  logic                   br_resolve,
   input  logic                   br_mispredict,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   busy_br
);

   localparam int CW = $clog2(DEPTH) + 1;

   sched_state_e    state_q, state_d;
   logic            full, empty, push, pop, flush;
   logic [UOPW-1:0] head, iss_uop_q;
   logic [CW-1:0]   count, count_nxt;
   logic            iss_valid_q;

   assign flush     = br_resolve && br_mispredict &&
                      (state_q == ST_BR_WAIT);
   assign dec_ready = !full && !flush;
   assign push      = dec_valid && dec_ready;
   assign pop       = (state_q == ST_ISSUE) && !empty;
   assign count_nxt = count + CW'(push) - CW'(pop);

   uop_fifo #(
      .DEPTH (DEPTH),
      .UOPW  (UOPW)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush),
      .push_i  (push),
      .wdata_i ({dec_opcode, dec_funct3, dec_funct7}),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (push) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (pop && is_branch(head[UOPW-1 -: 7]))
               state_d = ST_BR_WAIT;
            else if (count_nxt == '0)
               state_d = ST_IDLE;
         end
         ST_BR_WAIT: begin
            if (flush)
               state_d = ST_IDLE;
            else if (br_resolve)
               state_d = (count_nxt != '0) ? ST_ISSUE : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         iss_valid_q <= 1'b0;
         iss_uop_q   <= '0;
      end else begin
         state_q     <= state_d;
         iss_valid_q <= pop;
         if (pop) iss_uop_q <= head;
      end
   end

   assign iss_valid  = iss_valid_q;
   assign iss_opcode = iss_uop_q[16:10];
   assign iss_funct3 = iss_uop_q[9:7];
   assign iss_funct7 = iss_uop_q[6:0];
   assign occupancy  = count;
   assign busy_br    = (state_q == ST_BR_WAIT);

endmodule

// File: tb/tb_exec_issue_sched.sv
// Scoreboard bench for exec_issue_sched: expected uops queued on
// accept, compared in order as the issue port fires.
module tb_exec_issue_sched;

   localparam int DEPTH = 4;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_ALU  = 7'b0110011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       dec_valid = 1'b0;
   logic       dec_ready;
   logic [6:0] dec_opcode = '0;
   logic [2:0] dec_funct3 = '0;
   logic [6:0] dec_funct7 = '0;
   logic       iss_valid;
   logic [6:0] iss_opcode;
   logic [2:0] iss_funct3;
   logic [6:0] iss_funct7;
   logic       br_resolve = 1'b0;
   logic       br_mispredict = 1'b0;
   logic [$clog2(DEPTH):0] occupancy;
   logic       busy_br;

   logic [16:0] exp_q[$];
   logic [16:0] m_exp, m_got;
   int checks = 0;
   int errors = 0;
   int n_iss = 0;

   always #5 clk = ~clk;

   exec_issue_sched #(.DEPTH(DEPTH), .UOPW(17)) dut (
      .clk           (clk),
      .reset         (reset),
      .dec_valid     (dec_valid),
      .dec_ready     (dec_ready),
      .dec_opcode    (dec_opcode),
      .dec_funct3    (dec_funct3),
      .dec_funct7    (dec_funct7),
      .iss_valid     (iss_valid),
      .iss_opcode    (iss_opcode),
      .iss_funct3    (iss_funct3),
      .iss_funct7    (iss_funct7),
      .br_resolve    (br_resolve),
      .br_mispredict (br_mispredict),
      .occupancy     (occupancy),
      .busy_br       (busy_br)
   );

   function automatic logic [16:0] mk(input logic [6:0] op,
                                      input logic [2:0] f3,
                                      input logic [6:0] f7);
      return {op, f3, f7};
   endfunction

   task automatic drive(input logic v, input logic [16:0] u, input bit exp);
      dec_valid = v;
      {dec_opcode, dec_funct3, dec_funct7} = u;
      if (exp) exp_q.push_back(u);
   endtask

   always @(posedge clk) begin
      #1;
      if (iss_valid === 1'b1) begin
         checks++;
         n_iss++;
         m_got = {iss_opcode, iss_funct3, iss_funct7};
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL iss_unexpected: got %h, required no issue", m_got);
         end else begin
            m_exp = exp_q.pop_front();
            if (m_got !== m_exp) begin
               errors++;
               $display("FAIL iss_order: got %h, required %h", m_got, m_exp);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL rst_iss_valid: got %b, required 0", iss_valid); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ: got %0d, required 0", occupancy); end
      checks++; if (busy_br !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy_br); end
      checks++; if ({iss_opcode, iss_funct3, iss_funct7} !== 17'd0) begin errors++; $display("FAIL rst_fields: got %h, required 0", {iss_opcode, iss_funct3, iss_funct7}); end
      reset = 1'b0;
      #1;
      checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, required 1", dec_ready); end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, mk(OP_ADDI, 3'd0, 7'(i)), 1'b1);
         #1;
         checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b, required 1", i, dec_ready); end
         @(negedge clk);
         checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL stream_occ[%0d]: got %0d, required 1", i, occupancy); end
         checks++; if (iss_valid !== (i >= 1)) begin errors++; $display("FAIL stream_valid[%0d]: got %b, required %b", i, iss_valid, (i >= 1)); end
      end
      drive(1'b0, 17'd0, 1'b0);
      @(negedge clk);
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL stream_drain_occ: got %0d, required 0", occupancy); end
      checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL stream_last: got %b, required 1", iss_valid); end
      @(negedge clk);
      checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL stream_idle: got %b, required 0", iss_valid); end
      checks++; if ({iss_opcode, iss_funct7} !== {OP_ADDI, 7'd7}) begin errors++; $display("FAIL stream_hold: got %h, required %h", {iss_opcode, iss_funct7}, {OP_ADDI, 7'd7}); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_left: got %0d, required 0", exp_q.size()); end
   endtask

   task automatic test_branch_hold();
      drive(1'b1, mk(OP_BEQ, 3'd0, 7'd0), 1'b1);
      @(negedge clk);
      checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL bh_occ0: got %0d, required 1", occupancy); end
      drive(1'b1, mk(OP_ALU, 3'd4, 7'd0), 1'b1);
      @(negedge clk);
      checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL bh_beq_iss: got %b, required 1", iss_valid); end
      checks++; if (busy_br !== 1'b1) begin errors++; $display("FAIL bh_busy: got %b, required 1", busy_br); end
      drive(1'b0, 17'd0, 1'b0);
      repeat (2) @(negedge clk);
      checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL bh_held: got %b, required 0", iss_valid); end
      checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL bh_occ1: got %0d, required 1", occupancy); end
      br_resolve = 1'b1;
      @(negedge clk);
      br_resolve = 1'b0;
      checks++; if (busy_br !== 1'b0) begin errors++; $display("FAIL bh_release: got %b, required 0", busy_br); end
      @(negedge clk);
      checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL bh_xor_iss: got %b, required 1", iss_valid); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bh_left: got %0d, required 0", exp_q.size()); end
      @(negedge clk);
   endtask

   task automatic test_fill();
      drive(1'b1, mk(OP_BEQ, 3'd1, 7'd0), 1'b1);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, mk(OP_ALU, 3'd0, 7'(8'h40 + i)), 1'b1);
         #1;
         checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b, required 1", i, dec_ready); end
         @(negedge clk);
      end
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_occ: got %0d, required 4", occupancy); end
      drive(1'b1, mk(OP_ALU, 3'd0, 7'h55), 1'b0);
      #1;
      checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got %b, required 0", dec_ready); end
      @(negedge clk);
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_drop: got %0d, required 4", occupancy); end
      br_resolve = 1'b1;
      @(negedge clk);
      br_resolve = 1'b0;
      drive(1'b1, mk(OP_ALU, 3'd0, 7'h66), 1'b0);
      #1;
      checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL fill_full_deq: got %b, required 0", dec_ready); end
      @(negedge clk);
      drive(1'b0, 17'd0, 1'b0);
      checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL fill_deq_occ: got %0d, required 3", occupancy); end
      repeat (4) @(negedge clk);
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL fill_drain: got %0d, required 0", occupancy); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fill_left: got %0d, required 0", exp_q.size()); end
   endtask

   task automatic test_mispredict();
      drive(1'b1, mk(OP_JAL, 3'd0, 7'd0), 1'b1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, mk(OP_ALU, 3'd0, 7'(8'h10 + i)), 1'b1);
         @(negedge clk);
      end
      checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL mp_occ3: got %0d, required 3", occupancy); end
      br_resolve = 1'b1;
      br_mispredict = 1'b1;
      drive(1'b1, mk(OP_ALU, 3'd0, 7'h1f), 1'b0);
      #1;
      checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL mp_ready: got %b, required 0", dec_ready); end
      @(negedge clk);
      exp_q.delete();
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL mp_occ: got %0d, required 0", occupancy); end
      checks++; if (busy_br !== 1'b0) begin errors++; $display("FAIL mp_busy: got %b, required 0", busy_br); end
      br_resolve = 1'b0;
      br_mispredict = 1'b0;
      drive(1'b0, 17'd0, 1'b0);
      @(negedge clk);
      checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL mp_noiss: got %b, required 0", iss_valid); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL mp_occ_after: got %0d, required 0", occupancy); end
   endtask

   task automatic test_reset_br();
      drive(1'b1, mk(OP_BEQ, 3'd0, 7'd1), 1'b1);
      @(negedge clk);
      drive(1'b1, mk(OP_ALU, 3'd0, 7'h21), 1'b1);
      @(negedge clk);
      drive(1'b1, mk(OP_ALU, 3'd0, 7'h22), 1'b1);
      @(negedge clk);
      checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL rb_occ2: got %0d, required 2", occupancy); end
      reset = 1'b1;
      drive(1'b1, mk(OP_ALU, 3'd0, 7'h2a), 1'b0);
      @(negedge clk);
      exp_q.delete();
      checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL rb_iss: got %b, required 0", iss_valid); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rb_occ: got %0d, required 0", occupancy); end
      checks++; if (busy_br !== 1'b0) begin errors++; $display("FAIL rb_busy: got %b, required 0", busy_br); end
      checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL rb_ready: got %b, required 1", dec_ready); end
      reset = 1'b0;
      drive(1'b0, 17'd0, 1'b0);
      @(negedge clk);
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rb_drop: got %0d, required 0", occupancy); end
   endtask

   task automatic test_stray();
      br_resolve = 1'b1;
      br_mispredict = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, mk(OP_ALU, 3'd0, 7'(8'h30 + i)), 1'b1);
         #1;
         checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL stray_ready[%0d]: got %b, required 1", i, dec_ready); end
         @(negedge clk);
         checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL stray_occ[%0d]: got %0d, required 1", i, occupancy); end
         checks++; if (busy_br !== 1'b0) begin errors++; $display("FAIL stray_busy[%0d]: got %b, required 0", i, busy_br); end
      end
      drive(1'b0, 17'd0, 1'b0);
      @(negedge clk);
      br_resolve = 1'b0;
      br_mispredict = 1'b0;
      checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL stray_last: got %b, required 1", iss_valid); end
      @(negedge clk);
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stray_left: got %0d, required 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_branch_hold();
      test_fill();
      test_mispredict();
      test_reset_br();
      test_stray();
      repeat (2) @(negedge clk);
      checks++;
      if (n_iss != 20) begin
         errors++;
         $display("FAIL issue_total: got %0d, required 20", n_iss);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
